// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Holds the FSM encoding, datapath width and the bubble word.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = '0;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_pc_register.sv
// Program counter register with sequential/redirect next-value mux.
// Ports: clk, rst (async high), load_en, sel_branch, branch_address,
//        pc_o (current pc), pc_inc_o (pc + PC_STEP, 32-bit wrap).
module if_fetch_stage_pc_register
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            sel_branch,
  input  logic [XLEN-1:0] branch_address,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_inc;

  // Modulo 2^32: the carry out is simply dropped.
  assign pc_inc = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      if (sel_branch) begin
        pc_d = branch_address;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign pc_inc_o = pc_inc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage feeding the IF/ID register.
// Ports: clk, rst (async high), freeze, branch_taken, branch_address,
//        imem_req/addr/rdata/ready, PC, Instruction, instr_valid,
//        fetch_wait. Bubbles are PC=0, Instruction=0.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic        fetch_wait
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] instr_buf_q;
  logic [XLEN-1:0] instr_buf_d;

  logic            pc_load;
  logic            pc_sel_br;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_inc;

  if_fetch_stage_pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .load_en        (pc_load),
    .sel_branch     (pc_sel_br),
    .branch_address (branch_address),
    .pc_o           (pc_reg),
    .pc_inc_o       (pc_inc)
  );

  // Next-state and pc control. branch_taken wins over freeze.
  always_comb begin
    state_d     = state_q;
    instr_buf_d = instr_buf_q;
    pc_load     = 1'b0;
    pc_sel_br   = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (branch_taken) begin
          pc_load   = 1'b1;
          pc_sel_br = 1'b1;
        end else if (imem_ready && !freeze) begin
          pc_load = 1'b1;
        end else if (imem_ready && freeze) begin
          instr_buf_d = imem_rdata;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_load     = 1'b1;
          pc_sel_br   = 1'b1;
          instr_buf_d = NOP_INSTR;
          state_d     = S_REQ;
        end else if (!freeze) begin
          pc_load     = 1'b1;
          instr_buf_d = NOP_INSTR;
          state_d     = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs depend only on state, pc, buffer and memory inputs.
  always_comb begin
    imem_req    = 1'b0;
    Instruction = NOP_INSTR;
    PC          = '0;
    instr_valid = 1'b0;
    fetch_wait  = 1'b0;
    unique case (state_q)
      S_REQ: begin
        imem_req   = 1'b1;
        fetch_wait = !imem_ready;
        if (imem_ready) begin
          Instruction = imem_rdata;
          PC          = pc_inc;
          instr_valid = 1'b1;
        end
      end
      S_HOLD: begin
        Instruction = instr_buf_q;
        PC          = pc_inc;
        instr_valid = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      instr_buf_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      instr_buf_q <= instr_buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a behavioural model.
// Memory returns addr ^ key; the model tracks pc and a held word.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        fetch_wait;

  logic [31:0] key;
  int          n_chk;
  int          n_fail;

  logic [31:0] m_pc;
  logic [31:0] m_hold[$];

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .PC             (PC),
    .Instruction    (Instruction),
    .instr_valid    (instr_valid),
    .fetch_wait     (fetch_wait)
  );

  assign imem_rdata = imem_addr ^ key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_hold.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_instr"}, Instruction, 32'h0);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, "_req"}, {31'b0, imem_req}, 32'h1);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  // One clock: drive, check at negedge, advance model, return at posedge+1.
  task automatic cyc(input bit fz, input bit br, input bit rdy,
                     input logic [31:0] ba);
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    bit          e_req;
    bit          e_valid;
    bit          e_wait;
    freeze         = fz;
    branch_taken   = br;
    branch_address = ba;
    imem_ready     = rdy;
    @(negedge clk);
    if (m_hold.size() != 0) begin
      e_req   = 1'b0;
      e_instr = m_hold[0];
      e_pc    = m_pc + 32'd4;
      e_valid = 1'b1;
      e_wait  = 1'b0;
    end else begin
      e_req   = 1'b1;
      e_wait  = !rdy;
      e_valid = rdy;
      e_instr = rdy ? mem(m_pc) : 32'h0;
      e_pc    = rdy ? m_pc + 32'd4 : 32'h0;
    end
    check("addr", imem_addr, m_pc);
    check("req", {31'b0, imem_req}, {31'b0, e_req});
    check("instr", Instruction, e_instr);
    check("pc", PC, e_pc);
    check("valid", {31'b0, instr_valid}, {31'b0, e_valid});
    check("wait", {31'b0, fetch_wait}, {31'b0, e_wait});
    if (m_hold.size() != 0) begin
      if (br) begin
        m_pc = ba;
        m_hold.delete();
      end else if (!fz) begin
        m_pc = m_pc + 32'd4;
        m_hold.delete();
      end
    end else begin
      if (br) m_pc = ba;
      else if (rdy && !fz) m_pc = m_pc + 32'd4;
      else if (rdy && fz) m_hold.push_back(mem(m_pc));
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check outputs before any edge.
  task automatic async_rst(input string tag);
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs(tag);
    check({tag, "_wait"}, {31'b0, fetch_wait}, 32'h1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    key            = 32'hA5A5_0000;
    rst            = 1'b1;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    imem_ready     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;

    // zero-wait streaming
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    check("zw_addr", imem_addr, 32'h10);

    // two wait states per word
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
    end

    // freeze on ready at addr 8, held 3 cycles
    cyc(0, 1, 0, 32'h8);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("unfrz_addr", imem_addr, 32'hC);

    // branch while held and frozen
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 32'h100);
    check("hold_br_addr", imem_addr, 32'h100);
    check("hold_br_req", {31'b0, imem_req}, 32'h1);

    // branch and ready in the same cycle at 0x20
    cyc(0, 1, 0, 32'h20);
    cyc(0, 1, 1, 32'h100);
    check("br_rdy_addr", imem_addr, 32'h100);

    // pc wrap
    cyc(0, 1, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // async reset mid-wait and from the hold state
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    async_rst("arst_wait");
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    async_rst("arst_hold");
    cyc(0, 0, 1, 0);

    // random traffic
    key = 32'h1357_9BDF;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 3,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 6,
          $urandom() & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
